// File: rtl/pc_unit_ras.sv
// pc_unit_ras: program counter with six next-PC sources and a circular return-address stack
module pc_unit_ras #(
   parameter int WIDTH = 32,
   parameter int JUMP_BITS = 26,
   parameter int RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h000000F8
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 PCWre,
   input  logic [2:0]           PCSrc,
   input  logic [WIDTH-1:0]     imm,
   input  logic [WIDTH-1:0]     readData1,
   input  logic [JUMP_BITS-1:0] target,
   output logic [WIDTH-1:0]     pcOut,
   output logic [WIDTH-1:0]     PC4,
   output logic                 ras_empty,
   output logic                 ras_full,
   output logic                 ras_err
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << (JUMP_BITS + 2)) - WIDTH'(1);
   logic [WIDTH-1:0] stack [RAS_DEPTH];
   logic [PW-1:0] ptr, top_ptr;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] jump_pc, next_pc;
   logic push, pop;
   assign PC4 = pcOut + WIDTH'(4);
   assign top_ptr = ptr - PW'(1);
   assign ras_empty = cnt == '0;
   assign ras_full = cnt == CW'(RAS_DEPTH);
   assign push = PCSrc == 3'b100;
   assign pop = PCSrc == 3'b101;
   // Upper PC4 bits are kept when the jump field does not cover the whole word
   assign jump_pc = (PC4 & ~LOW_MASK) | WIDTH'({target, 2'b00});
   always_comb
      next_pc = PCSrc == 3'b001 ? PC4 + (imm << 2) :
                PCSrc == 3'b010 ? readData1 :
                PCSrc == 3'b011 || push ? jump_pc :
                pop ? (ras_empty ? readData1 : stack[top_ptr]) :
                PC4;
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pcOut <= RESET_VECTOR;
         ptr <= '0;
         cnt <= '0;
         ras_err <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
      end else if (PCWre) begin
         pcOut <= next_pc;
         if (push) begin
            stack[ptr] <= PC4;
            ptr <= ptr + PW'(1);
            if (ras_full) ras_err <= 1'b1;
            else cnt <= cnt + CW'(1);
         end else if (pop) begin
            if (ras_empty) ras_err <= 1'b1;
            else begin
               ptr <= top_ptr;
               cnt <= cnt - CW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed and randomized checks of pc_unit_ras against a queue-based model
module tb_pc_unit_ras;
   logic CLK = 1'b0, Reset = 1'b1, PCWre = 1'b0;
   logic [2:0] PCSrc = 3'b000;
   logic [31:0] imm = '0, readData1 = '0;
   logic [25:0] target = '0;
   logic [31:0] pcOut, PC4;
   logic ras_empty, ras_full, ras_err;
   int n_assert = 0, n_fail = 0;
   logic [31:0] mpc = 32'hF8;
   logic [31:0] mq [$];
   logic merr = 1'b0;
   pc_unit_ras #(.WIDTH(32), .JUMP_BITS(26), .RAS_DEPTH(4), .RESET_VECTOR(32'h000000F8)) dut (
      .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .imm(imm),
      .readData1(readData1), .target(target), .pcOut(pcOut), .PC4(PC4),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
   );
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic check_all(input string tag);
      check({tag, ".pcOut"}, pcOut, mpc);
      check({tag, ".PC4"}, PC4, mpc + 32'd4);
      check({tag, ".empty"}, 32'(ras_empty), 32'(mq.size() == 0));
      check({tag, ".full"}, 32'(ras_full), 32'(mq.size() == 4));
      check({tag, ".err"}, 32'(ras_err), 32'(merr));
   endtask
   task automatic model_reset();
      mpc = 32'hF8;
      mq.delete();
      merr = 1'b0;
   endtask
   task automatic step(input string tag, input logic we, input logic [2:0] src,
                       input logic [31:0] im, input logic [31:0] rd, input logic [25:0] tg);
      logic [31:0] pc4;
      PCWre = we; PCSrc = src; imm = im; readData1 = rd; target = tg;
      pc4 = mpc + 32'd4;
      if (we) begin
         case (src)
            3'd1: mpc = pc4 + im * 32'd4;
            3'd2: mpc = rd;
            3'd3: mpc = {pc4[31:28], tg, 2'b00};
            3'd4: begin
               if (mq.size() == 4) begin
                  void'(mq.pop_front());
                  merr = 1'b1;
               end
               mq.push_back(pc4);
               mpc = {pc4[31:28], tg, 2'b00};
            end
            3'd5: begin
               if (mq.size() == 0) begin
                  merr = 1'b1;
                  mpc = rd;
               end else mpc = mq.pop_back();
            end
            default: mpc = pc4;
         endcase
      end
      @(posedge CLK);
      #1;
      check_all(tag);
   endtask
   task automatic async_reset(input string tag);
      #3;
      Reset = 1'b1;
      model_reset();
      #1;
      check_all(tag);
      #2;
      Reset = 1'b0;
   endtask
   initial begin
      repeat (2) @(posedge CLK);
      #1;
      check_all("reset");
      #2;
      Reset = 1'b0;
      // basic sequential flow
      for (int i = 0; i < 3; i++) step("seq", 1, 3'd0, 0, 0, 0);
      check("seq.const", pcOut, 32'h104);
      // branches both directions
      step("jr", 1, 3'd2, 0, 32'h100, 0);
      step("beq.neg", 1, 3'd1, 32'hFFFF_FFFE, 0, 0);
      check("beq.neg.const", pcOut, 32'hFC);
      step("beq.pos", 1, 3'd1, 32'd3, 0, 0);
      check("beq.pos.const", pcOut, 32'h10C);
      // jump keeps upper PC4 bits, then hold
      step("jr", 1, 3'd2, 0, 32'h1000_0010, 0);
      step("j", 1, 3'd3, 0, 0, 26'h40);
      check("j.const", pcOut, 32'h1000_0100);
      step("hold", 0, 3'd1, 32'd5, 0, 0);
      step("hold", 0, 3'd1, 32'd5, 0, 0);
      // nested calls
      step("jr", 1, 3'd2, 0, 32'h100, 0);
      step("jal1", 1, 3'd4, 0, 0, 26'h80);
      step("jal2", 1, 3'd4, 0, 0, 26'hC0);
      step("jal3", 1, 3'd4, 0, 0, 26'h100);
      step("ret1", 1, 3'd5, 0, 32'h999, 0);
      check("ret1.const", pcOut, 32'h304);
      step("ret2", 1, 3'd5, 0, 32'h999, 0);
      step("ret3", 1, 3'd5, 0, 32'h999, 0);
      check("ret3.const", pcOut, 32'h104);
      // overflow then underflow
      for (int k = 0; k < 5; k++) begin
         step("jr", 1, 3'd2, 0, 32'h9C + 32'(k) * 32'h10, 0);
         step("jal.ovf", 1, 3'd4, 0, 0, 26'h200);
      end
      check("ovf.full", 32'(ras_full), 32'd1);
      for (int k = 0; k < 5; k++) step("ret.ovf", 1, 3'd5, 0, 32'h500, 0);
      check("unf.const", pcOut, 32'h500);
      // async reset discards RAS contents
      async_reset("rst.mid0");
      step("jal", 1, 3'd4, 0, 0, 26'h300);
      step("jal", 1, 3'd4, 0, 0, 26'h310);
      async_reset("rst.mid");
      check("rst.mid.const", pcOut, 32'hF8);
      step("ret.after.rst", 1, 3'd5, 0, 32'h777, 0);
      // randomized mix
      for (int n = 0; n < 400; n++) begin
         int v;
         v = int'($urandom_range(0, 64)) - 32;
         if ($urandom_range(0, 49) == 0) async_reset("rnd.rst");
         step("rnd", $urandom_range(0, 5) != 0, 3'($urandom_range(0, 7)), 32'(v),
              $urandom & 32'hFFFF_FFFC, 26'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
